// File: rtl/ccd_linear_seq.sv
// Linear CCD timing sequencer: trigger delay, ROG/exposure timing, CLK readout and ADC strobes.
// Define CCD_FLUSH_READ_EN to insert a charge-flush clock burst between ROG1 and INTEG.
module ccd_linear_seq #(
  parameter int unsigned PIXELS    = 2048,
  parameter int unsigned HALF_DIV  = 24,
  parameter int unsigned GUARD_CYC = 300,
  parameter int unsigned UNIT_CYC  = 48000,
  parameter int unsigned DLY_DIV   = 24,
  parameter int unsigned ADC_OFS   = 12
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [15:0] int_time,
  input  logic [2:0]  trig_mode,
  input  logic [15:0] trig_delay,
  input  logic        aqui_src,
  input  logic        ext_trig,
  output logic        ccd_clk,
  output logic        ccd_rog,
  output logic        adc_start,
  output logic        adc_restart,
  output logic [15:0] pix_idx,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  localparam int unsigned PhW  = $clog2(2 * HALF_DIV);
  localparam int unsigned GrdW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
  localparam int unsigned DlyW = $clog2(65535 * DLY_DIV);
  localparam int unsigned PixW = $clog2(PIXELS);

  localparam logic [PhW-1:0]  PhLast  = PhW'(2 * HALF_DIV - 1);
  localparam logic [PhW-1:0]  PhHigh  = PhW'(HALF_DIV);
  localparam logic [PhW-1:0]  PhAdc   = PhW'(ADC_OFS);
  localparam logic [GrdW-1:0] GrdLoad = GrdW'(GUARD_CYC - 1);
  localparam logic [PixW-1:0] PerLast = PixW'(PIXELS - 1);
  localparam logic [15:0]     PixLast = 16'(PIXELS - 1);

  localparam logic [2:0] ModeFree  = 3'd0;
  localparam logic [2:0] ModeSoft  = 3'd1;
  localparam logic [2:0] ModeLevel = 3'd2;
  localparam logic [2:0] ModeSync  = 3'd3;
  localparam logic [2:0] ModeEdge  = 3'd4;

  typedef enum logic [3:0] {
    StIdle, StTdly, StPre, StRog1, StInteg, StRog2, StPost, StRead
`ifdef CCD_FLUSH_READ_EN
    , StFlush
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [DlyW-1:0] dly_q, dly_d;
  logic [GrdW-1:0] grd_q, grd_d;
  logic [31:0]     integ_q, integ_d;
  logic [PhW-1:0]  ph_q, ph_d;
  logic [PixW-1:0] per_q, per_d;
  logic [15:0]     pix_q, pix_d;
  logic [2:0]      mode_q, mode_d;
  logic [15:0]     itime_q, itime_d;
  logic            aqui_q, ext_q;

  logic ccd_clk_q, ccd_clk_d, ccd_rog_q, ccd_rog_d;
  logic adc_start_q, adc_start_d, adc_restart_q, adc_restart_d;
  logic busy_q, busy_d, frame_done_q, frame_done_d, overrun_q, overrun_d;

  logic [2:0]      mode_live;
  logic            aqui_rise, ext_rise, idle_evt, busy_evt, burst_d;
  logic [15:0]     units;
  logic [31:0]     int_load;
  logic [DlyW-1:0] dly_load;

  assign mode_live = (trig_mode > ModeEdge) ? ModeFree : trig_mode;
  assign aqui_rise = aqui_src & ~aqui_q;
  assign ext_rise  = ext_trig & ~ext_q;
  assign units     = (itime_q == 16'd0) ? 16'd1 : itime_q;
  assign int_load  = 32'(units) * UNIT_CYC - 32'd1;
  // trig_delay is captured straight into the delay counter at the start event.
  assign dly_load  = (trig_delay == 16'd0) ? '0 : DlyW'(32'(trig_delay) * DLY_DIV - 32'd1);

  // idle_evt starts a frame; busy_evt is what counts as a dropped request mid-frame.
  always_comb begin
    idle_evt = 1'b0;
    busy_evt = 1'b0;
    case (mode_live)
      ModeSoft: begin
        idle_evt = aqui_rise;
        busy_evt = aqui_rise;
      end
      ModeLevel: begin
        idle_evt = ext_trig;
        busy_evt = ext_rise;
      end
      ModeSync, ModeEdge: begin
        idle_evt = ext_rise;
        busy_evt = ext_rise;
      end
      default: idle_evt = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    grd_d   = grd_q;
    integ_d = integ_q;
    ph_d    = ph_q;
    per_d   = per_q;
    mode_d  = mode_q;
    itime_d = itime_q;
    pix_d   = pix_q;
    if (adc_start_q) pix_d = (pix_q == PixLast) ? 16'd0 : pix_q + 16'd1;

    unique case (state_q)
      StIdle: begin
        if (idle_evt) begin
          state_d = StTdly;
          mode_d  = mode_live;
          itime_d = int_time;
          dly_d   = dly_load;
          pix_d   = 16'd0;
        end
      end
      StTdly: begin
        if (dly_q == '0) begin
          state_d = StPre;
          grd_d   = GrdLoad;
        end else dly_d = dly_q - DlyW'(1);
      end
      StPre: begin
        if (grd_q == '0) begin
          state_d = StRog1;
          grd_d   = GrdLoad;
        end else grd_d = grd_q - GrdW'(1);
      end
      StRog1: begin
        if (grd_q == '0) begin
          if (mode_q == ModeSync) begin
            state_d = StPost;
            grd_d   = GrdLoad;
          end else begin
`ifdef CCD_FLUSH_READ_EN
            state_d = StFlush;
            ph_d    = '0;
            per_d   = '0;
`else
            state_d = StInteg;
            integ_d = int_load;
`endif
          end
        end else grd_d = grd_q - GrdW'(1);
      end
      StInteg: begin
        if (integ_q == 32'd0) begin
          state_d = StRog2;
          grd_d   = GrdLoad;
        end else integ_d = integ_q - 32'd1;
      end
      StRog2: begin
        if (grd_q == '0) begin
          state_d = StPost;
          grd_d   = GrdLoad;
        end else grd_d = grd_q - GrdW'(1);
      end
      StPost: begin
        if (grd_q == '0) begin
          state_d = StRead;
          ph_d    = '0;
          per_d   = '0;
        end else grd_d = grd_q - GrdW'(1);
      end
      StRead: begin
        if (ph_q == PhLast) begin
          ph_d = '0;
          if (per_q == PerLast) state_d = StIdle;
          else per_d = per_q + PixW'(1);
        end else ph_d = ph_q + PhW'(1);
      end
`ifdef CCD_FLUSH_READ_EN
      StFlush: begin
        if (ph_q == PhLast) begin
          ph_d = '0;
          if (per_q == PerLast) begin
            state_d = StInteg;
            integ_d = int_load;
          end else per_d = per_q + PixW'(1);
        end else ph_d = ph_q + PhW'(1);
      end
`endif
      default: state_d = StIdle;
    endcase

    // Outputs are registered from next-state values so they are glitch-free and in step with state.
    burst_d = (state_d == StRead);
`ifdef CCD_FLUSH_READ_EN
    burst_d = burst_d | (state_d == StFlush);
`endif
    ccd_clk_d     = ~(burst_d && (ph_d < PhHigh));
    ccd_rog_d     = ~((state_d == StRog1) || (state_d == StRog2));
    adc_start_d   = (state_d == StRead) && (ph_d == PhAdc);
    adc_restart_d = (state_d == StRog1) && (state_q != StRog1);
    frame_done_d  = (state_q == StRead) && (state_d == StIdle);
    overrun_d     = (state_q != StIdle) && busy_evt;
    busy_d        = (state_d != StIdle);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q       <= StIdle;
      dly_q         <= '0;
      grd_q         <= '0;
      integ_q       <= '0;
      ph_q          <= '0;
      per_q         <= '0;
      pix_q         <= '0;
      mode_q        <= '0;
      itime_q       <= '0;
      aqui_q        <= 1'b0;
      ext_q         <= 1'b0;
      ccd_clk_q     <= 1'b1;
      ccd_rog_q     <= 1'b1;
      adc_start_q   <= 1'b0;
      adc_restart_q <= 1'b0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      dly_q         <= dly_d;
      grd_q         <= grd_d;
      integ_q       <= integ_d;
      ph_q          <= ph_d;
      per_q         <= per_d;
      pix_q         <= pix_d;
      mode_q        <= mode_d;
      itime_q       <= itime_d;
      aqui_q        <= aqui_src;
      ext_q         <= ext_trig;
      ccd_clk_q     <= ccd_clk_d;
      ccd_rog_q     <= ccd_rog_d;
      adc_start_q   <= adc_start_d;
      adc_restart_q <= adc_restart_d;
      frame_done_q  <= frame_done_d;
      overrun_q     <= overrun_d;
      busy_q        <= busy_d;
    end
  end

  assign ccd_clk     = ccd_clk_q;
  assign ccd_rog     = ccd_rog_q;
  assign adc_start   = adc_start_q;
  assign adc_restart = adc_restart_q;
  assign pix_idx     = pix_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_ccd_linear_seq.sv
// Directed bench for ccd_linear_seq with small timing parameters and hand-computed expectations.
module tb_ccd_linear_seq;

  logic        sys_clk, sys_rst;
  logic [15:0] int_time, trig_delay;
  logic [2:0]  trig_mode;
  logic        aqui_src, ext_trig;
  logic        ccd_clk, ccd_rog, adc_start, adc_restart, busy, frame_done, overrun;
  logic [15:0] pix_idx;

  int vectors = 0;
  int miscompares = 0;

  ccd_linear_seq #(
    .PIXELS(16), .HALF_DIV(4), .GUARD_CYC(10), .UNIT_CYC(100), .DLY_DIV(24), .ADC_OFS(3)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .int_time(int_time), .trig_mode(trig_mode),
    .trig_delay(trig_delay), .aqui_src(aqui_src), .ext_trig(ext_trig), .ccd_clk(ccd_clk),
    .ccd_rog(ccd_rog), .adc_start(adc_start), .adc_restart(adc_restart), .pix_idx(pix_idx),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Waveform monitor, sampled on the falling clock edge.
  logic mon_clr = 1'b0;
  int cyc = 0, run_len = 0, rise_cyc = 0;
  int rog_runs = 0, rog_bad = 0, gap_cnt = 0, gap_last = 0, gap_min = 0, gap_max = 0;
  int adc_cnt = 0, pix_bad = 0, fd_cnt = 0, ovr_cnt = 0, ovr_wide = 0, rst_cnt = 0;
  int clkfall = 0, r2c_cnt = 0, r2c_bad = 0;
  logic rog_p = 1'b1, clk_p = 1'b1, ovr_p = 1'b0, rst_armed = 1'b0, gap_arm = 1'b0;
  logic r2c_arm = 1'b0;

  always @(negedge sys_clk) begin
    cyc <= cyc + 1;
    if (mon_clr) begin
      run_len <= 0; rog_runs <= 0; rog_bad <= 0; gap_cnt <= 0; gap_last <= 0;
      gap_min <= 1 << 30; gap_max <= 0; adc_cnt <= 0; pix_bad <= 0; fd_cnt <= 0;
      ovr_cnt <= 0; ovr_wide <= 0; rst_cnt <= 0; clkfall <= 0; r2c_cnt <= 0; r2c_bad <= 0;
      rog_p <= ccd_rog; clk_p <= ccd_clk; ovr_p <= overrun;
      rst_armed <= 1'b0; gap_arm <= 1'b0; r2c_arm <= 1'b0;
    end else begin
      if (!ccd_rog) run_len <= run_len + 1;
      if (ccd_rog && !rog_p) begin
        rog_runs <= rog_runs + 1;
        if (run_len != 10) rog_bad <= rog_bad + 1;
        run_len  <= 0;
        rise_cyc <= cyc;
        r2c_arm  <= 1'b1;
        if (rst_armed) begin
          gap_arm   <= 1'b1;
          rst_armed <= 1'b0;
        end
      end
      if (adc_restart) begin
        rst_cnt   <= rst_cnt + 1;
        rst_armed <= 1'b1;
        gap_arm   <= 1'b0;
      end
      if (!ccd_rog && rog_p && gap_arm && !adc_restart) begin
        gap_cnt  <= gap_cnt + 1;
        gap_last <= cyc - rise_cyc;
        if (cyc - rise_cyc < gap_min) gap_min <= cyc - rise_cyc;
        if (cyc - rise_cyc > gap_max) gap_max <= cyc - rise_cyc;
        gap_arm  <= 1'b0;
      end
      if (!ccd_clk && clk_p) begin
        clkfall <= clkfall + 1;
        if (r2c_arm) begin
          r2c_cnt <= r2c_cnt + 1;
          if (cyc - rise_cyc != 10) r2c_bad <= r2c_bad + 1;
          r2c_arm <= 1'b0;
        end
      end
      if (adc_start) begin
        adc_cnt <= adc_cnt + 1;
        if (pix_idx !== 16'(adc_cnt % 16)) pix_bad <= pix_bad + 1;
      end
      if (frame_done) fd_cnt <= fd_cnt + 1;
      if (overrun) ovr_cnt <= ovr_cnt + 1;
      if (overrun && ovr_p) ovr_wide <= ovr_wide + 1;
      rog_p <= ccd_rog;
      clk_p <= ccd_clk;
      ovr_p <= overrun;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic clr_mon();
    tick(1);
    mon_clr = 1'b1;
    tick(1);
    mon_clr = 1'b0;
  endtask

  task automatic wait_fd(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (fd_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    tick(3);
    vectors++;
    if ({ccd_clk, ccd_rog, adc_start, adc_restart, busy, frame_done, overrun} !== 7'b1100000) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want 1100000",
               {ccd_clk, ccd_rog, adc_start, adc_restart, busy, frame_done, overrun});
    end
    vectors++;
    if (pix_idx !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_pix_idx: got %0d want 0", pix_idx);
    end
    sys_rst = 1'b0;
    tick(20);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle_no_event: busy got %b want 0", busy);
    end
  endtask

  task automatic test_mode1_frame();
    bit ok;
    clr_mon();
    aqui_src = 1'b1;
    wait_fd(1, 2000, ok);
    tick(5);
    aqui_src = 1'b0;
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL m1_timeout: frame_done got 0 want 1"); end
    vectors++;
    if (rog_runs !== 2 || rog_bad !== 0) begin
      miscompares++;
      $display("FAIL m1_rog_pulses: runs %0d bad %0d want 2 and 0", rog_runs, rog_bad);
    end
    vectors++;
    if (gap_cnt !== 1 || gap_last !== 200) begin
      miscompares++;
      $display("FAIL m1_integ_gap: count %0d gap %0d want 1 and 200", gap_cnt, gap_last);
    end
    vectors++;
    if (adc_cnt !== 16 || pix_bad !== 0) begin
      miscompares++;
      $display("FAIL m1_adc: pulses %0d pix errors %0d want 16 and 0", adc_cnt, pix_bad);
    end
    vectors++;
    if (clkfall !== 16 || rst_cnt !== 1 || fd_cnt !== 1 || ovr_cnt !== 0) begin
      miscompares++;
      $display("FAIL m1_counts: falls %0d restarts %0d done %0d ovr %0d want 16 1 1 0",
               clkfall, rst_cnt, fd_cnt, ovr_cnt);
    end
    vectors++;
    if (busy !== 1'b0 || ccd_clk !== 1'b1 || pix_idx !== 16'd0) begin
      miscompares++;
      $display("FAIL m1_end_state: busy %b clk %b pix %0d want 0 1 0", busy, ccd_clk, pix_idx);
    end
  endtask

  task automatic test_trig_delay();
    bit ok;
    int n;
    clr_mon();
    trig_delay = 16'd5;
    aqui_src   = 1'b1;
    n = 0;
    for (int i = 1; i <= 1000; i++) begin
      tick(1);
      if (adc_restart) begin
        n = i;
        break;
      end
    end
    vectors++;
    if (n !== 131) begin
      miscompares++;
      $display("FAIL dly_start_to_restart: got %0d cycles want 131", n);
    end
    wait_fd(1, 2000, ok);
    aqui_src   = 1'b0;
    trig_delay = 16'd0;
    vectors++;
    if (!ok || adc_cnt !== 16) begin
      miscompares++;
      $display("FAIL dly_frame: done %0d adc %0d want 1 and 16", ok, adc_cnt);
    end
    tick(3);
  endtask

  task automatic test_overrun();
    bit ok;
    clr_mon();
    aqui_src = 1'b1;
    tick(3);
    aqui_src = 1'b0;
    tick(100);
    aqui_src = 1'b1;
    tick(3);
    aqui_src = 1'b0;
    wait_fd(1, 2000, ok);
    tick(400);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL ovr_timeout: frame_done got 0 want 1"); end
    vectors++;
    if (ovr_cnt !== 1 || ovr_wide !== 0) begin
      miscompares++;
      $display("FAIL ovr_pulse: pulses %0d long %0d want 1 and 0", ovr_cnt, ovr_wide);
    end
    vectors++;
    if (fd_cnt !== 1 || rst_cnt !== 1 || adc_cnt !== 16 || gap_last !== 200) begin
      miscompares++;
      $display("FAIL ovr_frame: done %0d restarts %0d adc %0d gap %0d want 1 1 16 200",
               fd_cnt, rst_cnt, adc_cnt, gap_last);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ovr_no_second_frame: busy got %b want 0", busy);
    end
  endtask

  task automatic test_mode0_back_to_back();
    bit ok;
    int idle_ok;
    clr_mon();
    int_time  = 16'd0;
    trig_mode = 3'd0;
    wait_fd(3, 3000, ok);
    trig_mode = 3'd1;
    idle_ok = 0;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (busy === 1'b0) begin
        idle_ok = 1;
        break;
      end
    end
    tick(2);
    vectors++;
    if (!ok || idle_ok !== 1) begin
      miscompares++;
      $display("FAIL m0_timeout: frames %0d idle %0d want 1 and 1", ok, idle_ok);
    end
    vectors++;
    if (fd_cnt !== 4 || rst_cnt !== 4 || gap_cnt !== 4) begin
      miscompares++;
      $display("FAIL m0_frames: done %0d restarts %0d gaps %0d want 4 4 4",
               fd_cnt, rst_cnt, gap_cnt);
    end
    vectors++;
    if (gap_min !== 100 || gap_max !== 100) begin
      miscompares++;
      $display("FAIL m0_integ_gap: min %0d max %0d want 100 and 100", gap_min, gap_max);
    end
    vectors++;
    if (ovr_cnt !== 0 || adc_cnt !== 64 || pix_bad !== 0) begin
      miscompares++;
      $display("FAIL m0_adc_ovr: ovr %0d adc %0d pix errors %0d want 0 64 0",
               ovr_cnt, adc_cnt, pix_bad);
    end
    int_time = 16'd2;
  endtask

  task automatic test_mode3_sync();
    bit ok;
    clr_mon();
    trig_mode = 3'd3;
    ext_trig  = 1'b1;
    tick(3);
    ext_trig  = 1'b0;
    tick(400);
    ext_trig  = 1'b1;
    tick(3);
    ext_trig  = 1'b0;
    wait_fd(2, 1000, ok);
    tick(3);
    trig_mode = 3'd1;
    vectors++;
    if (!ok || fd_cnt !== 2) begin
      miscompares++;
      $display("FAIL m3_frames: done %0d want 2", fd_cnt);
    end
    vectors++;
    if (rog_runs !== 2 || rog_bad !== 0 || gap_cnt !== 0) begin
      miscompares++;
      $display("FAIL m3_no_rog2: runs %0d bad %0d rog2 %0d want 2 0 0", rog_runs, rog_bad, gap_cnt);
    end
    vectors++;
    if (r2c_cnt !== 2 || r2c_bad !== 0) begin
      miscompares++;
      $display("FAIL m3_rog1_to_read: count %0d bad %0d want 2 and 0", r2c_cnt, r2c_bad);
    end
    vectors++;
    if (adc_cnt !== 32 || pix_bad !== 0 || ovr_cnt !== 0) begin
      miscompares++;
      $display("FAIL m3_adc: adc %0d pix errors %0d ovr %0d want 32 0 0", adc_cnt, pix_bad, ovr_cnt);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    int seen;
    clr_mon();
    aqui_src = 1'b1;
    seen = 0;
    for (int i = 0; i < 2000; i++) begin
      tick(1);
      if (adc_cnt >= 5) begin
        seen = 1;
        break;
      end
    end
    #2;
    sys_rst = 1'b1;
    #1;
    vectors++;
    if (seen !== 1) begin miscompares++; $display("FAIL ar_reach_read: got 0 want 1"); end
    vectors++;
    if ({ccd_clk, ccd_rog, adc_start, adc_restart, busy, frame_done, overrun} !== 7'b1100000 ||
        pix_idx !== 16'd0) begin
      miscompares++;
      $display("FAIL ar_immediate: got %b pix %0d want 1100000 pix 0",
               {ccd_clk, ccd_rog, adc_start, adc_restart, busy, frame_done, overrun}, pix_idx);
    end
    aqui_src = 1'b0;
    tick(3);
    sys_rst = 1'b0;
    tick(3);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ar_idle_after: busy got %b want 0", busy);
    end
    clr_mon();
    aqui_src = 1'b1;
    wait_fd(1, 2000, ok);
    tick(3);
    aqui_src = 1'b0;
    vectors++;
    if (!ok || adc_cnt !== 16 || pix_bad !== 0 || rog_runs !== 2 || gap_last !== 200) begin
      miscompares++;
      $display("FAIL ar_clean_frame: done %0d adc %0d pix errors %0d runs %0d gap %0d",
               ok, adc_cnt, pix_bad, rog_runs, gap_last);
    end
  endtask

  initial begin
    sys_rst    = 1'b1;
    trig_mode  = 3'd1;
    int_time   = 16'd2;
    trig_delay = 16'd0;
    aqui_src   = 1'b0;
    ext_trig   = 1'b0;
    test_reset();
    test_mode1_frame();
    test_trig_delay();
    test_overrun();
    test_mode0_back_to_back();
    test_mode3_sync();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
